// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory port between the fetch unit and the memory arbiter.
// The fetch unit is the master: it raises a request with a byte address, the
// arbiter grants it in the same cycle and returns the byte one cycle later.
interface inst_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_grant;
   logic [7:0]  mem_din;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_grant,
      input  mem_din
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_grant,
      output mem_din
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage for a byte-wide memory port.
// A 32-bit instruction is assembled from four byte reads, requested in order
// pc+0..pc+3 and captured little-endian one cycle after each grant.
// Requests overlap captures, so with a permanently granting arbiter a whole
// word takes five edges. While fetching, the stage asks the stall controller to
// hold IF and bubble ID; once the word is complete it is presented in HOLD
// until the pipeline accepts it. A branch redirect overrides everything.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           stall,
   input  logic                 branch_flag,
   input  logic [31:0]          branch_target,
   inst_fetch_if.master         bus,
   output logic [31:0]          if_pc,
   output logic [31:0]          if_inst,
   output logic                 stallreq_if
);

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [2:0]  grant_cnt;
   logic        in_flight;
   logic [1:0]  cap_idx;
   logic [23:0] low_bytes;

   logic        requesting;
   logic        granted;

   // Only stall[0] concerns this stage; the upper bits belong to later stages.
   logic        unused_stall_bits;
   assign unused_stall_bits = ^stall[5:1];

   // Request/bubble signalling follows the state directly so that a request is
   // on the bus in the very first cycle after reset or a redirect. Gating with
   // rst keeps every output quiet while reset is asserted.
   always_comb begin
      requesting   = 1'b0;
      granted      = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_addr = 32'h0;
      stallreq_if  = 1'b0;
      if (!rst && state == FETCH) begin
         stallreq_if = 1'b1;
         if (grant_cnt != 3'd4) begin
            requesting   = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc + {29'b0, grant_cnt};
            granted      = bus.mem_grant;
         end
      end
   end

   // Fetch FSM: counts grants, captures returning bytes, and hands the finished
   // word to IF/ID through registered if_pc/if_inst (zero while fetching).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         grant_cnt <= 3'd0;
         in_flight <= 1'b0;
         cap_idx   <= 2'd0;
         low_bytes <= 24'h0;
         if_pc     <= 32'h0;
         if_inst   <= 32'h0;
      end else if (branch_flag) begin
         state     <= FETCH;
         pc        <= branch_target;
         grant_cnt <= 3'd0;
         in_flight <= 1'b0;
         cap_idx   <= 2'd0;
         low_bytes <= 24'h0;
         if_pc     <= 32'h0;
         if_inst   <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               in_flight <= granted;
               if (granted) begin
                  grant_cnt <= grant_cnt + 3'd1;
                  cap_idx   <= grant_cnt[1:0];
               end
               if (in_flight) begin
                  case (cap_idx)
                     2'd0: low_bytes[7:0]   <= bus.mem_din;
                     2'd1: low_bytes[15:8]  <= bus.mem_din;
                     2'd2: low_bytes[23:16] <= bus.mem_din;
                     default: begin
                        if_inst <= {bus.mem_din, low_bytes};
                        if_pc   <= pc;
                        state   <= HOLD;
                     end
                  endcase
               end
            end
            HOLD: begin
               if (stall[0] == NOSTOP) begin
                  state     <= FETCH;
                  pc        <= pc + 32'd4;
                  grant_cnt <= 3'd0;
                  in_flight <= 1'b0;
                  cap_idx   <= 2'd0;
                  low_bytes <= 24'h0;
                  if_pc     <= 32'h0;
                  if_inst   <= 32'h0;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // STOP is the held value of stall[0]; kept named so the hold path reads clearly.
   logic unused_stop_const;
   assign unused_stop_const = STOP;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset (`RstEnable`).
REQ-004 stall  input  6  pipeline stall vector; stall[0]==`STOP` freezes the PC/fetch hand-off.
REQ-005 branch_flag  input  1  one-cycle redirect request from the execute stage.
REQ-006 branch_target  input  32  redirect PC, sampled when branch_flag=1.
REQ-007 mem_req  output  1  byte-read request to the memory arbiter.
REQ-008 mem_addr  output  32  byte address of the current request.
REQ-009 mem_grant  input  1  arbiter accepts the request in the same cycle.
REQ-010 mem_din  input  8  read byte, valid exactly one cycle after a granted request.
REQ-011 if_pc  output  32  PC of the delivered instruction, to the IF/ID register.
REQ-012 if_inst  output  32  delivered instruction, to the IF/ID register.
REQ-013 stallreq_if  output  1  asks the stall controller to hold IF and bubble ID.

Function
REQ-014 The block SHALL have states FETCH (byte request/capture) and HOLD (instruction complete).
REQ-015 In FETCH, mem_req SHALL be 1 while fewer than 4 bytes are granted; mem_addr SHALL be pc + granted-byte count (0..3).
REQ-016 An ungranted request (mem_grant=0) SHALL be held unchanged, same address, next cycle.
REQ-017 The cycle after each granted request, mem_din SHALL be captured little-endian: byte k into if_inst[8k+7:8k].
REQ-018 Request of byte k+1 SHALL overlap capture of byte k; with grant held high, HOLD is entered on the 5th posedge after entering FETCH.
REQ-019 After capturing byte 3, the block SHALL enter HOLD; captures and grants in FETCH never exceed 4.
REQ-020 In FETCH, stallreq_if SHALL be 1, if_inst SHALL be 32'h0 and if_pc SHALL be 32'h0 (bubble).
REQ-021 In HOLD, stallreq_if SHALL be 0, mem_req 0, if_pc = pc, if_inst = assembled word.
REQ-022 In HOLD with stall[0]==`NOSTOP` at a posedge, pc SHALL become pc+4 (32-bit wrap) and the state FETCH with counts cleared.
REQ-023 In HOLD with stall[0]==`STOP`, pc, if_inst and state SHALL hold.
REQ-024 branch_flag=1 at a posedge SHALL override all else: pc <= branch_target, state <= FETCH, counts cleared, in-flight capture cancelled.
REQ-025 A byte returning in the cycle after a branch edge SHALL be discarded; the first target byte is requested in that same cycle.
REQ-026 branch_target is used as-is; no alignment check is performed.

Reset
REQ-027 While rst=1: pc=RESET_PC, state=FETCH, counts=0, in-flight=0, mem_req=0, mem_addr=0, if_pc=0, if_inst=0, stallreq_if=0.
REQ-028 Reset SHALL abort any fetch mid-operation; the first request (mem_addr=RESET_PC) is issued in the first cycle after rst deasserts.

Verification
REQ-029 Reset release, grant=1, bytes 13,05,00,00 at 0..3 -> addresses 0,1,2,3 on consecutive cycles; HOLD with if_inst=32'h00000513, if_pc=0, stallreq_if=0 on 5th edge.
REQ-030 HOLD, stall=6'b000000 -> next cycle mem_addr=4, stallreq_if=1, if_inst=0; stall=6'b000011 in HOLD -> pc, if_inst held for every stalled cycle.
REQ-031 grant=0 for 3 cycles on byte 2 -> mem_addr stays pc+2, no extra capture, final word still correct, HOLD 3 cycles later than REQ-029.
REQ-032 branch_flag=1, target=32'h1000 while byte 1 in flight -> stale byte discarded, next mem_addr=32'h1000, HOLD yields if_pc=32'h1000 and target's word.
REQ-033 pc=32'hFFFFFFFC, HOLD, stall=0 -> next fetch mem_addr=32'h00000000 (wrap).
REQ-034 rst pulsed during byte 2 capture -> all outputs 0 immediately, restart at RESET_PC.
